dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-ported byte-addressable data memory. It shares the memory between port 0 (pipeline MEM stage) and port 1 (debug/program loader). It registers the arbitration decision, drives the memory's read/write strobes, address, func3 and write data for one cycle per transaction, and returns registered read data. Misaligned accesses are blocked before they reach memory.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_align_chk.sv | 25 ++
 rtl/dmem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_e    : arbiter FSM states (IDLE / SERVE0 / SERVE1)
//   - F3_*           : RISC-V load/store func3 encodings used for alignment
//   - STARVE_MAX_DEF : default number of consecutive port-0 grants tolerated
//                      while port 1 waits
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational alignment check for one requester.
//   func3   in  3 : RISC-V load/store width encoding
//   addr_lo in  2 : low two bits of the byte address
//   aligned out 1 : 1 when the access may be forwarded to memory
// Unknown func3 values are reported aligned; the memory decides what they mean.
module dmem_align_chk
  import dmem_arb_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [1:0] addr_lo,
  output logic       aligned
);

  // Width-dependent alignment rule
  always_comb begin
    aligned = 1'b1;
    case (func3)
      F3_W:        aligned = (addr_lo == 2'b00);
      F3_H, F3_HU: aligned = ~addr_lo[0];
      F3_B, F3_BU: aligned = 1'b1;
      default:     aligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   pX_req/we/addr/func3/wdata : request from port X (0 = MEM stage, 1 = debug)
//   pX_gnt                     : transaction for port X executes this cycle
//   pX_rvalid/rdata/err        : completion one cycle after the grant
//                                (loads and misaligned accesses only)
//   mem_MemRead/MemWrite/addr/func3/data_in : memory request, valid in grant cycle
//   mem_data_out               : combinational read data from memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [2:0]        p0_func3,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [2:0]        p1_func3,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func3,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  logic             p0_aligned_s;
  logic             p1_aligned_s;
  logic             p0_elig_s;
  logic             p1_elig_s;

  dmem_align_chk u_align0 (
    .func3   (p0_func3),
    .addr_lo (p0_addr[1:0]),
    .aligned (p0_aligned_s)
  );

  dmem_align_chk u_align1 (
    .func3   (p1_func3),
    .addr_lo (p1_addr[1:0]),
    .aligned (p1_aligned_s)
  );

  // Next-state arbitration and starvation counter update
  always_comb begin
    state_nxt_s      = IDLE;
    starve_cnt_nxt_s = starve_cnt_r;
    // A port being served right now still shows its current request; it
    // must not be counted as a new one.
    p0_elig_s = p0_req & (state_r != SERVE0);
    p1_elig_s = p1_req & (state_r != SERVE1);

    if (p1_elig_s && (!p0_elig_s || (starve_cnt_r == STARVE_LIM))) begin
      state_nxt_s = SERVE1;
    end else if (p0_elig_s) begin
      state_nxt_s = SERVE0;
    end else begin
      state_nxt_s = IDLE;
    end

    if (!p1_req || (state_nxt_s == SERVE1)) begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else if ((state_nxt_s == SERVE0) && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_nxt_s = starve_cnt_r + CNT_ONE;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // FSM state and starvation counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  assign p0_gnt = (state_r == SERVE0);
  assign p1_gnt = (state_r == SERVE1);

  // Memory request mux; strobes are suppressed for misaligned accesses
  always_comb begin
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_func3    = 3'b000;
    mem_data_in  = {DATA_W{1'b0}};
    case (state_r)
      SERVE0: begin
        mem_addr     = p0_addr;
        mem_func3    = p0_func3;
        mem_data_in  = p0_wdata;
        mem_MemRead  = ~p0_we & p0_aligned_s;
        mem_MemWrite =  p0_we & p0_aligned_s;
      end
      SERVE1: begin
        mem_addr     = p1_addr;
        mem_func3    = p1_func3;
        mem_data_in  = p1_wdata;
        mem_MemRead  = ~p1_we & p1_aligned_s;
        mem_MemWrite =  p1_we & p1_aligned_s;
      end
      default: begin
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
      end
    endcase
  end

  // Port 0 completion: load data or error status, one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= {DATA_W{1'b0}};
    end else begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      if (state_r == SERVE0) begin
        if (!p0_aligned_s) begin
          p0_rvalid <= 1'b1;
          p0_err    <= 1'b1;
          p0_rdata  <= {DATA_W{1'b0}};
        end else if (!p0_we) begin
          p0_rvalid <= 1'b1;
          p0_rdata  <= mem_data_out;
        end else begin
          p0_rdata  <= p0_rdata;
        end
      end
    end
  end

  // Port 1 completion: load data or error status, one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= {DATA_W{1'b0}};
    end else begin
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      if (state_r == SERVE1) begin
        if (!p1_aligned_s) begin
          p1_rvalid <= 1'b1;
          p1_err    <= 1'b1;
          p1_rdata  <= {DATA_W{1'b0}};
        end else if (!p1_we) begin
          p1_rvalid <= 1'b1;
          p1_rdata  <= mem_data_out;
        end else begin
          p1_rdata  <= p1_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a 64-byte memory sits behind the DUT,
// two requester queues drive the ports, and a transaction-level model predicts
// grants, strobes and completions every cycle.
module tb_dmem_arbiter;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [2:0]    p0_func3, p1_func3;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_MemRead, mem_MemWrite;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_data_in, mem_data_out;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_func3(p0_func3), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_func3(p1_func3), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_addr(mem_addr),
    .mem_func3(mem_func3), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Little-endian load formatting shared by the memory and the model.
  function automatic logic [31:0] rd_fmt(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h000000, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'h0000, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // ---------------- data memory behind the DUT ----------------
  logic [7:0]    mem [0:63];
  logic          mem_clear;
  logic [AW-1:0] ma1, ma2, ma3;
  assign ma1 = mem_addr + 6'd1;
  assign ma2 = mem_addr + 6'd2;
  assign ma3 = mem_addr + 6'd3;
  assign mem_data_out = rd_fmt(mem[mem_addr], mem[ma1], mem[ma2], mem[ma3], mem_func3);

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (mem_MemWrite) begin
      case (mem_func3[1:0])
        2'b00: mem[mem_addr] <= mem_data_in[7:0];
        2'b01: begin
          mem[mem_addr] <= mem_data_in[7:0];
          mem[ma1]      <= mem_data_in[15:8];
        end
        default: begin
          mem[mem_addr] <= mem_data_in[7:0];
          mem[ma1]      <= mem_data_in[15:8];
          mem[ma2]      <= mem_data_in[23:16];
          mem[ma3]      <= mem_data_in[31:24];
        end
      endcase
    end
  end

  // ---------------- requesters ----------------
  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [2:0]  f3;
    logic [31:0] wd;
  } txn_t;
  txn_t q0[$];
  txn_t q1[$];

  // ---------------- transaction-level model ----------------
  logic [7:0]  ref_mem [0:63];
  int          cur;          // port executing this cycle, -1 = none
  int          starve;
  logic [1:0]  e_rv, e_err;
  logic [31:0] e_rd0, e_rd1;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic bit ok_align(input logic [2:0] f3, input logic [5:0] a);
    int sz;
    case (f3)
      3'b010:         sz = 4;
      3'b001, 3'b101: sz = 2;
      default:        sz = 1;
    endcase
    return (int'(a) % sz) == 0;
  endfunction

  function automatic int wrap(input int a);
    return a % 64;
  endfunction

  task automatic model_reset();
    cur = -1; starve = 0; e_rv = 2'b00; e_err = 2'b00; e_rd0 = 32'h0; e_rd1 = 32'h0;
  endtask

  task automatic model_complete(input int p);
    txn_t t;
    t.we   = (p == 0) ? p0_we    : p1_we;
    t.addr = (p == 0) ? p0_addr  : p1_addr;
    t.f3   = (p == 0) ? p0_func3 : p1_func3;
    t.wd   = (p == 0) ? p0_wdata : p1_wdata;
    if (!ok_align(t.f3, t.addr)) begin
      e_rv[p] = 1'b1; e_err[p] = 1'b1;
      if (p == 0) e_rd0 = 32'h0; else e_rd1 = 32'h0;
    end else if (!t.we) begin
      e_rv[p] = 1'b1;
      if (p == 0)
        e_rd0 = rd_fmt(ref_mem[t.addr], ref_mem[wrap(t.addr + 1)], ref_mem[wrap(t.addr + 2)], ref_mem[wrap(t.addr + 3)], t.f3);
      else
        e_rd1 = rd_fmt(ref_mem[t.addr], ref_mem[wrap(t.addr + 1)], ref_mem[wrap(t.addr + 2)], ref_mem[wrap(t.addr + 3)], t.f3);
    end else begin
      for (int i = 0; i < ((t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4); i++)
        ref_mem[wrap(t.addr + i)] = t.wd[8*i +: 8];
    end
    if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  // Advance the model across one rising edge.
  task automatic model_step();
    bit c0, c1;
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_rv = 2'b00; e_err = 2'b00;
    if (cur >= 0) model_complete(cur);
    c0 = p0_req && (cur != 0);
    c1 = p1_req && (cur != 1);
    if (c1 && (!c0 || starve == SMAX)) nxt = 1;
    else if (c0) nxt = 0;
    else nxt = -1;
    if (!p1_req || nxt == 1) starve = 0;
    else if (nxt == 0 && starve < SMAX) starve = starve + 1;
    cur = nxt;
  endtask

  task automatic drive();
    if (q0.size() > 0) begin
      p0_req = 1'b1; p0_we = q0[0].we; p0_addr = q0[0].addr; p0_func3 = q0[0].f3; p0_wdata = q0[0].wd;
    end else begin
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = 6'd0; p0_func3 = 3'd0; p0_wdata = 32'h0;
    end
    if (q1.size() > 0) begin
      p1_req = 1'b1; p1_we = q1[0].we; p1_addr = q1[0].addr; p1_func3 = q1[0].f3; p1_wdata = q1[0].wd;
    end else begin
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = 6'd0; p1_func3 = 3'd0; p1_wdata = 32'h0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic        emr, emw;
    logic [31:0] ea, ef, ed;
    emr = 1'b0; emw = 1'b0; ea = 32'h0; ef = 32'h0; ed = 32'h0;
    if (cur == 0) begin
      ea = 32'(p0_addr); ef = 32'(p0_func3); ed = p0_wdata;
      emr = !p0_we && ok_align(p0_func3, p0_addr);
      emw =  p0_we && ok_align(p0_func3, p0_addr);
    end else if (cur == 1) begin
      ea = 32'(p1_addr); ef = 32'(p1_func3); ed = p1_wdata;
      emr = !p1_we && ok_align(p1_func3, p1_addr);
      emw =  p1_we && ok_align(p1_func3, p1_addr);
    end
    chk("gnt0", 32'(p0_gnt), 32'(cur == 0));
    chk("gnt1", 32'(p1_gnt), 32'(cur == 1));
    chk("rvalid0", 32'(p0_rvalid), 32'(e_rv[0]));
    chk("rvalid1", 32'(p1_rvalid), 32'(e_rv[1]));
    chk("err0", 32'(p0_err), 32'(e_err[0]));
    chk("err1", 32'(p1_err), 32'(e_err[1]));
    chk("rdata0", p0_rdata, e_rd0);
    chk("rdata1", p1_rdata, e_rd1);
    chk("MemRead", 32'(mem_MemRead), 32'(emr));
    chk("MemWrite", 32'(mem_MemWrite), 32'(emw));
    chk("mem_addr", 32'(mem_addr), ea);
    chk("mem_func3", 32'(mem_func3), ef);
    chk("mem_data_in", mem_data_in, ed);
  endtask

  // One clock: model follows the edge, new requests appear, outputs checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive();
    @(negedge clk);
    #1;
    compare_model();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      tick(); n++;
    end
    chk("drain_timeout", 32'(q0.size() + q1.size()), 32'h0);
    tick(); tick();
  endtask

  task automatic await_gnt(input int p, input string nm);
    int n;
    n = 0;
    while (!((p == 0) ? p0_gnt : p1_gnt) && n < 12) begin
      tick(); n++;
    end
    chk(nm, 32'((p == 0) ? p0_gnt : p1_gnt), 32'h1);
  endtask

  task automatic await_rv(input int p, input logic [31:0] exp_d, input logic exp_e, input string nm);
    int n;
    n = 0;
    while (!((p == 0) ? p0_rvalid : p1_rvalid) && n < 12) begin
      tick(); n++;
    end
    chk({nm, "_rvalid"}, 32'((p == 0) ? p0_rvalid : p1_rvalid), 32'h1);
    chk({nm, "_rdata"}, (p == 0) ? p0_rdata : p1_rdata, exp_d);
    chk({nm, "_err"}, 32'((p == 0) ? p0_err : p1_err), 32'(exp_e));
  endtask

  function automatic txn_t mk(input logic we, input logic [5:0] a, input logic [2:0] f3, input logic [31:0] wd);
    txn_t t;
    t.we = we; t.addr = a; t.f3 = f3; t.wd = wd;
    return t;
  endfunction

  initial begin
    int p0_run;
    bit seen1;
    rst_n = 1'b0;
    mem_clear = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    model_reset();
    drive();
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    // reset state
    chk("rst_gnt0", 32'(p0_gnt), 32'h0);
    chk("rst_MemWrite", 32'(mem_MemWrite), 32'h0);
    chk("rst_rdata1", p1_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Memory bytes 0..3 = 20,9,4,0, then a single port-0 word load.
    q1.push_back(mk(1'b1, 6'd0, 3'b010, 32'h00040914));
    drain(20);
    q0.push_back(mk(1'b0, 6'd0, 3'b010, 32'h0));
    tick();
    chk("lw_N_gnt0", 32'(p0_gnt), 32'h0);
    tick();
    chk("lw_N1_gnt0", 32'(p0_gnt), 32'h1);
    chk("lw_N1_MemRead", 32'(mem_MemRead), 32'h1);
    tick();
    chk("lw_N2_rvalid0", 32'(p0_rvalid), 32'h1);
    chk("lw_N2_rdata0", p0_rdata, 32'h00040914);
    chk("lw_N2_err0", 32'(p0_err), 32'h0);
    drain(20);

    // Store then byte loads on port 1.
    q1.push_back(mk(1'b1, 6'd8,  3'b010, 32'hDEADBEEF));
    q1.push_back(mk(1'b0, 6'd9,  3'b100, 32'h0));
    q1.push_back(mk(1'b0, 6'd11, 3'b000, 32'h0));
    await_rv(1, 32'h000000BE, 1'b0, "lbu9");
    tick();
    await_rv(1, 32'hFFFFFFDE, 1'b0, "lb11");
    drain(20);

    // Contention: both ports busy, strict alternation starting with port 0.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 6'(4 * i), 3'b010, 32'h0));
      q1.push_back(mk(1'b0, 6'(8 + i), 3'b100, 32'h0));
    end
    await_gnt(0, "cont_first_p0");
    for (int i = 0; i < 8; i++) begin
      chk("cont_gnt0", 32'(p0_gnt), 32'((i % 2) == 0));
      chk("cont_gnt1", 32'(p1_gnt), 32'((i % 2) == 1));
      chk("cont_starve_le1", 32'(dut.starve_cnt_r <= 2'd1), 32'h1);
      tick();
    end
    drain(20);

    // Starvation bound: port 0 keeps requesting while port 1 waits.
    for (int i = 0; i < 6; i++) q0.push_back(mk(1'b0, 6'(4 * i), 3'b010, 32'h0));
    q1.push_back(mk(1'b0, 6'd12, 3'b010, 32'h0));
    p0_run = 0; seen1 = 1'b0;
    for (int i = 0; i < 20 && !seen1; i++) begin
      tick();
      if (p0_gnt) p0_run++;
      if (p1_gnt) seen1 = 1'b1;
    end
    chk("starve_p1_served", 32'(seen1), 32'h1);
    chk("starve_p0_run_le_max", 32'(p0_run <= SMAX), 32'h1);
    drain(30);

    // Misaligned LW @2 on port 0 and SH @5 on port 1.
    q0.push_back(mk(1'b0, 6'd2, 3'b010, 32'h0));
    await_gnt(0, "mis_lw_gnt");
    chk("mis_lw_MemRead", 32'(mem_MemRead), 32'h0);
    tick();
    chk("mis_lw_rvalid", 32'(p0_rvalid), 32'h1);
    chk("mis_lw_err", 32'(p0_err), 32'h1);
    chk("mis_lw_rdata", p0_rdata, 32'h0);
    q1.push_back(mk(1'b1, 6'd5, 3'b001, 32'h0000BEEF));
    await_gnt(1, "mis_sh_gnt");
    chk("mis_sh_MemWrite", 32'(mem_MemWrite), 32'h0);
    tick();
    chk("mis_sh_rvalid", 32'(p1_rvalid), 32'h1);
    chk("mis_sh_err", 32'(p1_err), 32'h1);
    chk("mis_sh_mem5", 32'(mem[5]), 32'h0);
    chk("mis_sh_mem6", 32'(mem[6]), 32'h0);
    q0.push_back(mk(1'b0, 6'd4, 3'b010, 32'h0));
    await_rv(0, 32'h0, 1'b0, "mis_readback");
    drain(20);

    // Reset during a port-0 store grant cycle.
    q0.push_back(mk(1'b1, 6'd16, 3'b010, 32'h11223344));
    await_gnt(0, "rst_st_gnt");
    chk("rst_st_MemWrite_before", 32'(mem_MemWrite), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_st_gnt0", 32'(p0_gnt), 32'h0);
    chk("rst_st_MemWrite", 32'(mem_MemWrite), 32'h0);
    chk("rst_st_addr", 32'(mem_addr), 32'h0);
    chk("rst_st_data_in", mem_data_in, 32'h0);
    chk("rst_st_rdata1", p1_rdata, 32'h0);
    q0.delete();
    q1.delete();
    model_reset();
    q1.push_back(mk(1'b0, 6'd16, 3'b010, 32'h0));
    drive();
    tick();
    tick();
    chk("rst_st_mem16", {mem[19], mem[18], mem[17], mem[16]}, 32'h0);
    rst_n = 1'b1;
    await_rv(1, 32'h0, 1'b0, "rst_readback");
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
